// File: rtl/demux_pkt_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_pkt_dispatcher
//
// Packet-level 1x2 demux. Steers one valid/ready input stream to one of two
// registered output channels. Each packet is locked to a single channel from
// its first beat through its last beat. The channel comes either from the
// in_dest tag on the first beat (MODE 0) or from a per-packet round-robin
// pointer (MODE 1).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   en                       start enable (gates only the first beat of a packet)
//   in_valid/in_ready        input handshake (in_ready is combinational)
//   in_data/in_dest/in_last  input beat payload, destination tag, end of packet
//   out0_* / out1_*          registered output channels (valid/ready/data/last)
//   pkt_cnt0 / pkt_cnt1      wrapping count of packets delivered per channel
//   busy                     packet open or any output beat still pending
// ---------------------------------------------------------------------------
module demux_pkt_dispatcher #(
  parameter int DATA_W = 8,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  input  logic              in_last,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic rr_ptr;
  logic dest_reg;
  logic tgt;
  logic can_accept0;
  logic can_accept1;
  logic tgt_can_accept;
  logic accept;
  logic load0;
  logic load1;

  // A channel can take a new beat when its register is empty or is being
  // drained this very cycle, which is what gives bubble-free throughput.
  assign can_accept0 = ~out0_valid | out0_ready;
  assign can_accept1 = ~out1_valid | out1_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a packet opens on an accepted non-last first beat and
  // closes on its accepted last beat; single-beat packets never leave IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && !in_last) state_next = PKT;
      PKT:  if (accept && in_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: target channel selection, input ready and busy.
  // Once a packet is open, en no longer matters so the packet always finishes.
  always_comb begin
    tgt      = dest_reg;
    in_ready = 1'b0;
    busy     = out0_valid | out1_valid;
    case (state)
      IDLE: begin
        tgt      = (MODE == 1) ? rr_ptr : in_dest;
        in_ready = en & tgt_can_accept;
      end
      PKT: begin
        tgt      = dest_reg;
        in_ready = tgt_can_accept;
        busy     = 1'b1;
      end
      default: begin
        tgt      = dest_reg;
        in_ready = 1'b0;
      end
    endcase
  end

  assign tgt_can_accept = tgt ? can_accept1 : can_accept0;
  assign accept         = in_valid & in_ready;
  assign load0          = accept & ~tgt;
  assign load1          = accept & tgt;

  // Destination lock and round-robin pointer. The pointer advances once per
  // packet (on its last beat) and only in round-robin mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_reg <= 1'b0;
      rr_ptr   <= 1'b0;
    end else begin
      if (state == IDLE && accept && !in_last) begin
        dest_reg <= tgt;
      end
      if (MODE == 1 && accept && in_last) begin
        rr_ptr <= ~rr_ptr;
      end
    end
  end

  // Channel 0 output register. A load wins over a drain so a simultaneous
  // drain-and-load leaves the register valid with the new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out0_last  <= 1'b0;
    end else if (load0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
      out0_last  <= in_last;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  // Channel 1 output register, same behaviour as channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
      out1_last  <= in_last;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

  // Delivered-packet counters: a packet counts when its last beat leaves the
  // output register. Natural overflow gives the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready && out0_last) begin
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      end
      if (out1_valid && out1_ready && out1_last) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_pkt_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_demux_pkt_dispatcher
//
// Two instances share the stimulus: dut_a (MODE 0, 2-bit counters) and dut_b
// (MODE 1, 8-bit counters). Only the selected instance sees in_valid. A
// packet-level reference model predicts ready/busy and the contents of each
// channel's output slot; directed steps add fixed-value checks.
// ---------------------------------------------------------------------------
module tb_demux_pkt_dispatcher;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic in_valid_a, in_valid_b;
  logic [7:0] in_data;
  logic in_dest, in_last;
  logic out0_ready, out1_ready;

  logic a_in_ready, a_out0_valid, a_out0_last, a_out1_valid, a_out1_last, a_busy;
  logic [7:0] a_out0_data, a_out1_data;
  logic [1:0] a_pkt_cnt0, a_pkt_cnt1;
  logic b_in_ready, b_out0_valid, b_out0_last, b_out1_valid, b_out1_last, b_busy;
  logic [7:0] b_out0_data, b_out1_data;
  logic [7:0] b_pkt_cnt0, b_pkt_cnt1;

  always #5 clk = ~clk;

  demux_pkt_dispatcher #(.DATA_W(8), .MODE(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid_a), .in_ready(a_in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_last(in_last),
    .out0_valid(a_out0_valid), .out0_ready(out0_ready), .out0_data(a_out0_data), .out0_last(a_out0_last),
    .out1_valid(a_out1_valid), .out1_ready(out1_ready), .out1_data(a_out1_data), .out1_last(a_out1_last),
    .pkt_cnt0(a_pkt_cnt0), .pkt_cnt1(a_pkt_cnt1), .busy(a_busy)
  );

  demux_pkt_dispatcher #(.DATA_W(8), .MODE(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid_b), .in_ready(b_in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_last(in_last),
    .out0_valid(b_out0_valid), .out0_ready(out0_ready), .out0_data(b_out0_data), .out0_last(b_out0_last),
    .out1_valid(b_out1_valid), .out1_ready(out1_ready), .out1_data(b_out1_data), .out1_last(b_out1_last),
    .pkt_cnt0(b_pkt_cnt0), .pkt_cnt1(b_pkt_cnt1), .busy(b_busy)
  );

  // Observed view of the selected instance
  logic sel;
  logic obs_in_ready, obs_busy;
  logic obs_v [2];
  logic obs_l [2];
  logic [7:0] obs_d [2];
  logic [7:0] obs_cnt [2];

  always_comb begin
    obs_in_ready = sel ? b_in_ready   : a_in_ready;
    obs_busy     = sel ? b_busy       : a_busy;
    obs_v[0]     = sel ? b_out0_valid : a_out0_valid;
    obs_v[1]     = sel ? b_out1_valid : a_out1_valid;
    obs_l[0]     = sel ? b_out0_last  : a_out0_last;
    obs_l[1]     = sel ? b_out1_last  : a_out1_last;
    obs_d[0]     = sel ? b_out0_data  : a_out0_data;
    obs_d[1]     = sel ? b_out1_data  : a_out1_data;
    obs_cnt[0]   = sel ? b_pkt_cnt0   : {6'b0, a_pkt_cnt0};
    obs_cnt[1]   = sel ? b_pkt_cnt1   : {6'b0, a_pkt_cnt1};
  end

  // Reference model: packet open/locked channel, round-robin turn, and the
  // single beat each output slot may hold.
  bit       m_open, m_dest, m_rr;
  bit       m_v [2];
  bit       m_l [2];
  bit [7:0] m_d [2];
  int       m_cnt [2];

  int passed = 0;
  int total  = 0;
  logic last_in_ready;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkRegs();
    for (int c = 0; c < 2; c++) begin
      checkOutput($sformatf("out%0d_valid", c), 32'(obs_v[c]), 32'(m_v[c]));
      checkOutput($sformatf("out%0d_data", c),  32'(obs_d[c]), 32'(m_d[c]));
      checkOutput($sformatf("out%0d_last", c),  32'(obs_l[c]), 32'(m_l[c]));
      checkOutput($sformatf("pkt_cnt%0d", c),   32'(obs_cnt[c]), 32'(m_cnt[c]));
    end
  endtask

  task automatic modelReset();
    m_open = 0; m_dest = 0; m_rr = 0;
    for (int c = 0; c < 2; c++) begin
      m_v[c] = 0; m_l[c] = 0; m_d[c] = 8'h00; m_cnt[c] = 0;
    end
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic doReset();
    in_valid_a = 0; in_valid_b = 0;
    rst = 1'b1;
    #1;
    modelReset();
    checkRegs();
    checkOutput("busy_in_reset", 32'(obs_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkRegs();
  endtask

  // One cycle: drive at the falling edge, check combinational outputs, step
  // the model across the rising edge, check registered outputs.
  task automatic applyStimulus(input bit v, input bit [7:0] d, input bit dest,
                               input bit last, input bit e, input bit r0, input bit r1);
    bit rdy [2];
    bit tgt, exp_ready, acc;
    in_valid_a = sel ? 1'b0 : v;
    in_valid_b = sel ? v : 1'b0;
    in_data = d; in_dest = dest; in_last = last; en = e;
    out0_ready = r0; out1_ready = r1;
    rdy[0] = r0; rdy[1] = r1;
    #1;
    tgt       = m_open ? m_dest : (sel ? m_rr : dest);
    exp_ready = (!m_v[tgt] || rdy[tgt]) && (m_open || e);
    last_in_ready = obs_in_ready;
    checkOutput("in_ready", 32'(obs_in_ready), 32'(exp_ready));
    checkOutput("busy", 32'(obs_busy), 32'(m_open || m_v[0] || m_v[1]));
    acc = v && exp_ready;
    for (int c = 0; c < 2; c++) begin
      if (m_v[c] && rdy[c]) begin
        if (m_l[c]) m_cnt[c] = (m_cnt[c] + 1) % (sel ? 256 : 4);
        m_v[c] = 0;
      end
    end
    if (acc) begin
      m_v[tgt] = 1; m_d[tgt] = d; m_l[tgt] = last;
      if (!m_open && !last) begin
        m_open = 1; m_dest = tgt;
      end else if (m_open && last) begin
        m_open = 0;
      end
      if (sel && last) m_rr = !m_rr;
    end
    @(negedge clk);
    #1;
    checkRegs();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sel = 1'b0;
    in_valid_a = 0; in_valid_b = 0; in_data = 0; in_dest = 0; in_last = 0;
    out0_ready = 0; out1_ready = 0;
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // 1. Reset mid-packet, then idle state after release
    $display("[TB] reset mid-packet");
    sel = 0;
    applyStimulus(1, 8'h55, 0, 0, 1, 0, 0);
    checkOutput("t1_out0_valid_before_reset", 32'(obs_v[0]), 32'd1);
    @(negedge clk);
    doReset();
    applyStimulus(0, 8'h00, 0, 0, 1, 1, 1);
    checkOutput("t1_in_ready_idle", 32'(last_in_ready), 32'd1);
    checkOutput("t1_cnt0", 32'(obs_cnt[0]), 32'd0);

    // 2. MODE 0 routing with mid-packet tag change
    $display("[TB] mode0 routing");
    applyStimulus(1, 8'hA1, 1, 0, 1, 1, 1);
    checkOutput("t2_beat1", 32'(obs_d[1]), 32'hA1);
    applyStimulus(1, 8'hA2, 0, 0, 1, 1, 1);
    checkOutput("t2_beat2", 32'(obs_d[1]), 32'hA2);
    applyStimulus(1, 8'hA3, 0, 1, 1, 1, 1);
    checkOutput("t2_beat3", 32'(obs_d[1]), 32'hA3);
    checkOutput("t2_out0_idle", 32'(obs_v[0]), 32'd0);
    applyStimulus(0, 8'h00, 0, 0, 1, 1, 1);
    checkOutput("t2_pkt_cnt1", 32'(obs_cnt[1]), 32'd1);

    // 3. MODE 1 round-robin, in_dest ignored
    $display("[TB] mode1 round-robin");
    sel = 1;
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'(8'h10 + i), 1, 1, 1, 1, 1);
      checkOutput($sformatf("t3_beat%0d", i), 32'(obs_d[i % 2]), 32'(8'h10 + i));
    end
    applyStimulus(0, 8'h00, 1, 0, 1, 1, 1);
    checkOutput("t3_pkt_cnt0", 32'(obs_cnt[0]), 32'd2);
    checkOutput("t3_pkt_cnt1", 32'(obs_cnt[1]), 32'd2);

    // 4. Backpressure and bubble-free refill
    $display("[TB] backpressure");
    sel = 0;
    doReset();
    applyStimulus(1, 8'hB0, 0, 0, 1, 0, 1);
    applyStimulus(1, 8'hB1, 0, 1, 1, 0, 1);
    checkOutput("t4_stall_ready", 32'(last_in_ready), 32'd0);
    checkOutput("t4_held_data", 32'(obs_d[0]), 32'hB0);
    applyStimulus(1, 8'hB1, 0, 1, 1, 1, 1);
    checkOutput("t4_refill_ready", 32'(last_in_ready), 32'd1);
    checkOutput("t4_refill_data", 32'(obs_d[0]), 32'hB1);
    checkOutput("t4_refill_valid", 32'(obs_v[0]), 32'd1);

    // 5. en gating: open packet completes, next start waits for en
    $display("[TB] enable gating");
    applyStimulus(1, 8'hC0, 1, 0, 1, 1, 1);
    applyStimulus(1, 8'hC1, 1, 0, 0, 1, 1);
    applyStimulus(1, 8'hC2, 1, 1, 0, 1, 1);
    checkOutput("t5_tail_data", 32'(obs_d[1]), 32'hC2);
    applyStimulus(1, 8'hD0, 0, 1, 0, 1, 1);
    checkOutput("t5_gated_ready", 32'(last_in_ready), 32'd0);
    applyStimulus(1, 8'hD0, 0, 1, 1, 1, 1);
    checkOutput("t5_enabled_ready", 32'(last_in_ready), 32'd1);

    // 6. Counter wrap with 2-bit counters
    $display("[TB] counter wrap");
    doReset();
    applyStimulus(1, 8'hE0, 0, 1, 1, 1, 1);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(1, 8'(8'hE0 + i), 0, 1, 1, 1, 1);
      checkOutput($sformatf("t6_cnt_after_%0d", i), 32'(obs_cnt[0]), 32'(i % 4));
    end
    applyStimulus(0, 8'h00, 0, 0, 1, 1, 1);
    checkOutput("t6_cnt_after_5", 32'(obs_cnt[0]), 32'd1);

    // Randomized traffic on both modes
    for (int s = 0; s < 2; s++) begin
      $display("[TB] random traffic mode %0d", s);
      sel = s[0];
      doReset();
      for (int n = 0; n < 400; n++) begin
        applyStimulus(($urandom % 4) != 0, 8'($urandom), 1'($urandom), ($urandom % 3) == 0,
                      ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux_pkt_dispatcher.md
Name: demux_pkt_dispatcher

Overview:
- Packet-level controller for the 1x2 demux datapath: steers a single valid/ready input stream to one of two output channels.
- Each packet is locked to one destination from its first beat through its `last` beat.
- Destination comes from a per-packet tag (MODE 0) or a round-robin pointer (MODE 1).
- A registered output stage on each channel gives 1-cycle latency and full throughput. Sits between a packet source and two downstream consumers.

Parameters:
- DATA_W, 8, data beat width in bits.
- MODE, 0, 0 = destination from in_dest sampled on the first beat; 1 = round-robin alternation per packet, in_dest ignored.
- CNT_W, 8, width of the per-channel delivered-packet counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  start enable; gates only the start of new packets.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready (combinational).
- in_data  input  DATA_W  input beat data.
- in_dest  input  1  destination tag; meaningful on the first beat of a packet only.
- in_last  input  1  marks the final beat of a packet.
- out0_valid  output  1  channel 0 beat valid (registered).
- out0_ready  input  1  channel 0 downstream ready.
- out0_data  output  DATA_W  channel 0 data (registered).
- out0_last  output  1  channel 0 last (registered).
- out1_valid  output  1  channel 1 beat valid (registered).
- out1_ready  input  1  channel 1 downstream ready.
- out1_data  output  DATA_W  channel 1 data (registered).
- out1_last  output  1  channel 1 last (registered).
- pkt_cnt0  output  CNT_W  packets delivered on channel 0, wrapping.
- pkt_cnt1  output  CNT_W  packets delivered on channel 1, wrapping.
- busy  output  1  high when state is PKT or either out*_valid is 1 (combinational).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, dest_reg=0.
  - All out*_valid/data/last = 0; pkt_cnt0 = pkt_cnt1 = 0.
  - Takes effect immediately; any packet in flight is discarded, including buffered output beats.
- FSM states: IDLE (no packet open) and PKT (packet open, locked to dest_reg).
- Target channel t:
  - In IDLE: t = in_dest (MODE 0) or rr_ptr (MODE 1).
  - In PKT: t = dest_reg.
- Channel c can accept when outc_valid=0 or outc_ready=1.
- in_ready:
  - IDLE: in_ready = en & (channel t can accept).
  - PKT: in_ready = (channel t can accept); en is ignored, so an open packet always completes.
- Accepted beat (in_valid & in_ready):
  - Next edge loads outt_data/outt_last from the input and sets outt_valid=1.
  - Latency is exactly 1 cycle; throughput is 1 beat/cycle when the downstream is ready.
- Output register for channel c, when not loaded this cycle:
  - outc_valid & outc_ready clears outc_valid.
  - Otherwise it holds; data and last stay stable while valid & !ready.
  - Simultaneous drain and load on the same channel leaves it valid with the new beat (no bubble).
- Transitions:
  - IDLE, accepted beat with in_last=0 -> PKT; dest_reg <= t.
  - IDLE, accepted beat with in_last=1 -> stays IDLE (single-beat packet).
  - PKT, accepted beat with in_last=1 -> IDLE.
  - Otherwise the state holds.
- Round-robin pointer: rr_ptr toggles on every accepted in_last beat in MODE 1. It does not move in MODE 0.
- Idle channel: the non-target channel may continue draining while the other channel receives.
- Packet counters: pkt_cntc increments by 1 on outc_valid & outc_ready & outc_last; wraps from 2^CNT_W-1 to 0.
- Mid-packet tag changes: in_dest changes while in PKT have no effect.
- en deasserted while in_valid is high in IDLE: no accept and no state change; the beat waits.
- The stream must not be dropped: in_valid held with in_ready low causes no state change.

Test Plan:
1. Reset/idle: assert rst mid-packet (state PKT, out0_valid=1) -> all outputs 0 immediately; after release with en=1, in_valid=0 -> in_ready=1, busy=0, counters 0.
2. MODE 0 routing: 3-beat packet 0xA1,0xA2,0xA3 (last on 3rd) with in_dest=1 on beat 1, then 0 on beats 2-3; out1_ready=1 -> out1 shows A1,A2,A3 on consecutive cycles one cycle after acceptance; out0_valid stays 0; pkt_cnt1=1.
3. MODE 1 round-robin: four single-beat packets 0x10..0x13, in_dest=1 constant -> 0x10,0x12 on ch0; 0x11,0x13 on ch1; pkt_cnt0=2, pkt_cnt1=2.
4. Backpressure: out0_ready=0 with a 2-beat packet to ch0 -> first beat held in out0, in_ready=0, out0_data stable; raise out0_ready -> second beat loads in the same cycle the first drains, no bubble.
5. en gating: deassert en during beat 2 of a 3-beat packet -> packet completes; next packet's first beat is not accepted (in_ready=0) until en=1.
6. Counter wrap (CNT_W=2): five single-beat packets to ch0 -> pkt_cnt0 sequence 1,2,3,0,1.
